mmio_arbiter: RTL

Two-master arbiter and sequencer in front of the memory-mapped I/O block. It lets the CPU data port (master 0) and a secondary requester such as a debug/DMA engine (master 1) share the single MMIO port, one transaction at a time. Arbitration is round-robin. Each transaction runs through a fixed issue, capture and acknowledge sequence, and the arbiter honours the MMIO wait signal.

---
 rtl/mmio_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_arbiter.sv
// Round-robin two-master arbiter/sequencer in front of the single MMIO port.
// Optional ISSUE stall timeout is enabled by defining MMIO_ARB_TIMEOUT_EN.
module mmio_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_byte_select,
  input  logic        m0_byte_enable,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  output logic        m0_hit,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_byte_select,
  input  logic        m1_byte_enable,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        m1_hit,
  output logic        m1_err,
  output logic        mmio_en,
  output logic        mmio_write_enable,
  output logic        mmio_byte_select,
  output logic        mmio_byte_enable,
  output logic [15:0] mmio_addr,
  output logic [15:0] mmio_data_in,
  input  logic [15:0] mmio_data_out,
  input  logic        mmio_serviced_read,
  input  logic        mmio_wait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t      state_r;
  logic        last_r;
  logic        gnt_r;

  logic        req_any_s;
  logic        sel_s;
  logic        sel_we_s;
  logic        sel_bs_s;
  logic        sel_be_s;
  logic [15:0] sel_addr_s;
  logic [15:0] sel_wdata_s;
  logic [15:0] cap_rdata_s;
  logic        cap_hit_s;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mmio_arbiter: TIMEOUT must lie in 1..65535");
  end

`ifdef MMIO_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt_r;
`endif

  // Pick a requester; on a tie the master that was not served last wins.
  always_comb begin
    req_any_s = 1'b0;
    sel_s     = 1'b0;
    if (m0_req && m1_req) begin
      req_any_s = 1'b1;
      sel_s     = ~last_r;
    end else if (m0_req) begin
      req_any_s = 1'b1;
      sel_s     = 1'b0;
    end else if (m1_req) begin
      req_any_s = 1'b1;
      sel_s     = 1'b1;
    end else begin
      req_any_s = 1'b0;
      sel_s     = 1'b0;
    end
  end

  // Request fields of the selected master, latched on grant.
  always_comb begin
    sel_we_s    = m0_we;
    sel_bs_s    = m0_byte_select;
    sel_be_s    = m0_byte_enable;
    sel_addr_s  = m0_addr;
    sel_wdata_s = m0_wdata;
    if (sel_s) begin
      sel_we_s    = m1_we;
      sel_bs_s    = m1_byte_select;
      sel_be_s    = m1_byte_enable;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_bs_s    = m0_byte_select;
      sel_be_s    = m0_byte_enable;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Completion data: reads take MMIO's registered result, writes report zero.
  always_comb begin
    cap_rdata_s = 16'h0000;
    cap_hit_s   = 1'b0;
    if (mmio_write_enable) begin
      cap_rdata_s = 16'h0000;
      cap_hit_s   = 1'b0;
    end else begin
      cap_rdata_s = mmio_data_out;
      cap_hit_s   = mmio_serviced_read;
    end
  end

  // Transaction sequencer: grant, issue, capture, acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      last_r            <= 1'b1;
      gnt_r             <= 1'b0;
      mmio_en           <= 1'b0;
      mmio_write_enable <= 1'b0;
      mmio_byte_select  <= 1'b0;
      mmio_byte_enable  <= 1'b0;
      mmio_addr         <= 16'h0000;
      mmio_data_in      <= 16'h0000;
      m0_ack            <= 1'b0;
      m0_rdata          <= 16'h0000;
      m0_hit            <= 1'b0;
      m0_err            <= 1'b0;
      m1_ack            <= 1'b0;
      m1_rdata          <= 16'h0000;
      m1_hit            <= 1'b0;
      m1_err            <= 1'b0;
`ifdef MMIO_ARB_TIMEOUT_EN
      wait_cnt_r        <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            gnt_r             <= sel_s;
            last_r            <= sel_s;
            mmio_en           <= 1'b1;
            mmio_write_enable <= sel_we_s;
            mmio_byte_select  <= sel_bs_s;
            mmio_byte_enable  <= sel_be_s;
            mmio_addr         <= sel_addr_s;
            mmio_data_in      <= sel_wdata_s;
`ifdef MMIO_ARB_TIMEOUT_EN
            wait_cnt_r        <= 16'h0000;
`endif
            state_r           <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (!mmio_wait) begin
            mmio_en <= 1'b0;
            state_r <= CAPTURE;
          end
`ifdef MMIO_ARB_TIMEOUT_EN
          else if (wait_cnt_r == TIMEOUT_LAST) begin
            // Stall limit reached: abandon the access and report an error.
            wait_cnt_r <= wait_cnt_r + 16'd1;
            mmio_en    <= 1'b0;
            m0_ack     <= ~gnt_r;
            m1_ack     <= gnt_r;
            m0_err     <= ~gnt_r;
            m1_err     <= gnt_r;
            m0_rdata   <= 16'h0000;
            m1_rdata   <= 16'h0000;
            m0_hit     <= 1'b0;
            m1_hit     <= 1'b0;
            state_r    <= ACK;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
            state_r    <= ISSUE;
          end
`else
          else begin
            state_r <= ISSUE;
          end
`endif
        end
        CAPTURE: begin
          m0_ack   <= ~gnt_r;
          m1_ack   <= gnt_r;
          m0_rdata <= gnt_r ? 16'h0000 : cap_rdata_s;
          m1_rdata <= gnt_r ? cap_rdata_s : 16'h0000;
          m0_hit   <= gnt_r ? 1'b0 : cap_hit_s;
          m1_hit   <= gnt_r ? cap_hit_s : 1'b0;
          m0_err   <= 1'b0;
          m1_err   <= 1'b0;
          state_r  <= ACK;
        end
        ACK: begin
          m0_ack   <= 1'b0;
          m0_rdata <= 16'h0000;
          m0_hit   <= 1'b0;
          m0_err   <= 1'b0;
          m1_ack   <= 1'b0;
          m1_rdata <= 16'h0000;
          m1_hit   <= 1'b0;
          m1_err   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          mmio_en  <= 1'b0;
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
